uart_tx_core: RTL and testbench

//   Serialises parallel bytes onto a UART line (start, data LSB-first, optional parity, stop).
//   It is the transmit end of the UART link whose receive path drives rx_data_valid_o/rx_data_o.
//   It plugs into the uart top as the engine behind tx_data_ready_o/tx_data_valid_i/tx_data_i/tx_o.

---
 rtl/uart_tx_core.sv | 109 ++++++++++
 tb/tb_uart_tx_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Frames chain back-to-back when a byte is accepted in the last cycle of the final stop bit.
module uart_tx_core #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 tx_data_valid_i,
   output logic                 tx_data_ready_o,
   input  logic [DATA_BITS-1:0] tx_data_i,
   output logic                 tx_busy_o,
   output logic                 tx_o
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   logic [BW-1:0]        baud;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;

   logic baud_end;
   logic last_cycle;
   logic accept;

   assign baud_end   = (baud == BW'(CLKS_PER_BIT - 1));
   assign last_cycle = (state == STOP) && (idx == IW'(STOP_BITS - 1)) && baud_end;
   assign tx_data_ready_o = en_i && !rst_i && ((state == IDLE) || last_cycle);
   assign accept     = tx_data_valid_i && tx_data_ready_o;
   assign tx_busy_o  = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         tx_o  <= 1'b1;
         baud  <= '0;
         idx   <= '0;
         shreg <= '0;
         par   <= 1'b0;
      end else if (accept) begin
         // Capture here so the source may change the byte on the very next cycle.
         state <= START;
         tx_o  <= 1'b0;
         baud  <= '0;
         idx   <= '0;
         shreg <= tx_data_i;
         par   <= (^tx_data_i) ^ 1'(PARITY_ODD);
      end else if (state == IDLE) begin
         tx_o <= 1'b1;
         baud <= '0;
         idx  <= '0;
      end else if (!baud_end) begin
         baud <= baud + BW'(1);
      end else begin
         baud <= '0;
         case (state)
            START: begin
               state <= DATA;
               tx_o  <= shreg[0];
               idx   <= '0;
            end
            DATA: begin
               shreg <= shreg >> 1;
               if (idx == IW'(DATA_BITS - 1)) begin
                  idx <= '0;
                  if (PARITY_EN != 0) begin
                     state <= PARITY;
                     tx_o  <= par;
                  end else begin
                     state <= STOP;
                     tx_o  <= 1'b1;
                  end
               end else begin
                  idx  <= idx + IW'(1);
                  tx_o <= shreg[1];
               end
            end
            PARITY: begin
               state <= STOP;
               tx_o  <= 1'b1;
               idx   <= '0;
            end
            STOP: begin
               tx_o <= 1'b1;
               if (idx == IW'(STOP_BITS - 1)) begin
                  state <= IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx_o  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances cover 8N1, even/odd parity and two stop bits.
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] din;
   logic       vld  [4];
   logic       rdy  [4];
   logic       busy [4];
   logic       tx   [4];

   int errors = 0;
   int checks = 0;
   logic exp_bits[$];

   always #5 clk = ~clk;

   uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_valid_i(vld[0]), .tx_data_ready_o(rdy[0]),
      .tx_data_i(din), .tx_busy_o(busy[0]), .tx_o(tx[0]));
   uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_valid_i(vld[1]), .tx_data_ready_o(rdy[1]),
      .tx_data_i(din), .tx_busy_o(busy[1]), .tx_o(tx[1]));
   uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_valid_i(vld[2]), .tx_data_ready_o(rdy[2]),
      .tx_data_i(din), .tx_busy_o(busy[2]), .tx_o(tx[2]));
   uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_valid_i(vld[3]), .tx_data_ready_o(rdy[3]),
      .tx_data_i(din), .tx_busy_o(busy[3]), .tx_o(tx[3]));

   // Append one frame's line levels (one entry per bit period) to the expected queue.
   task automatic push_frame(input logic [7:0] d, input int par_en, input int par_odd, input int stops);
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
      if (par_en != 0) exp_bits.push_back((^d) ^ par_odd[0]);
      for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
   endtask

   // Offer a byte and return at the first sampling point after the accepting edge (frame cycle 0).
   task automatic start_send(input int i, input logic [7:0] d, input string name);
      int n;
      din    = d;
      vld[i] = 1'b1;
      n = 0;
      while (rdy[i] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s ready-timeout: ready=%b after %0d cycles, required 1", name, rdy[i], n);
      end
      @(negedge clk);
   endtask

   // Walk the expected queue cycle by cycle, checking line, busy and ready.
   task automatic check_frame(input int i, input int flen, input int drop_at, input int en_drop_at,
                              input logic [7:0] next_din, input string name);
      int   n;
      logic er;
      n = exp_bits.size() * 4;
      for (int k = 0; k < n; k++) begin
         checks++;
         if (tx[i] !== exp_bits[k / 4]) begin
            errors++;
            $display("FAIL %s tx cycle %0d: got %b, required %b", name, k, tx[i], exp_bits[k / 4]);
         end
         er = en && ((k % flen) == flen - 1);
         checks++;
         if (rdy[i] !== er) begin
            errors++;
            $display("FAIL %s ready cycle %0d: got %b, required %b", name, k, rdy[i], er);
         end
         checks++;
         if (busy[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cycle %0d: got %b, required 1", name, k, busy[i]);
         end
         if (k == 0) din = next_din;
         if (k == drop_at) vld[i] = 1'b0;
         if (k == en_drop_at) en = 1'b0;
         @(negedge clk);
      end
      exp_bits.delete();
   endtask

   task automatic check_idle(input int i, input string name);
      checks++;
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || rdy[i] !== en) begin
         errors++;
         $display("FAIL %s idle: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=%b",
                  name, tx[i], busy[i], rdy[i], en);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || rdy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset inst%0d: tx=%b busy=%b ready=%b, required 1 0 0", i, tx[i], busy[i], rdy[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_idle(i, "after_reset");
   endtask

   task automatic test_8n1;
      start_send(0, 8'h55, "8n1");
      push_frame(8'h55, 0, 0, 1);
      check_frame(0, 40, 0, -1, 8'h00, "8n1_0x55");
      check_idle(0, "8n1_end");
   endtask

   task automatic test_back_to_back;
      start_send(0, 8'hA5, "b2b");
      push_frame(8'hA5, 0, 0, 1);
      push_frame(8'h3C, 0, 0, 1);
      check_frame(0, 40, 40, -1, 8'h3C, "b2b");
      check_idle(0, "b2b_end");
   endtask

   task automatic test_parity;
      start_send(1, 8'h07, "even");
      push_frame(8'h07, 1, 0, 1);
      checks++;
      if (exp_bits[9] !== 1'b1) begin
         errors++;
         $display("FAIL even model parity: got %b, required 1", exp_bits[9]);
      end
      check_frame(1, 44, 0, -1, 8'h00, "even_0x07");
      check_idle(1, "even_end");
      start_send(2, 8'h07, "odd");
      push_frame(8'h07, 1, 1, 1);
      check_frame(2, 44, 0, -1, 8'h00, "odd_0x07");
      check_idle(2, "odd_end");
   endtask

   task automatic test_two_stop;
      start_send(3, 8'hFF, "stop2");
      push_frame(8'hFF, 0, 0, 2);
      check_frame(3, 44, 0, -1, 8'h00, "stop2_0xFF");
      check_idle(3, "stop2_end");
   endtask

   task automatic test_mid_reset;
      start_send(0, 8'h81, "rst");
      push_frame(8'h81, 0, 0, 1);
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (tx[0] !== exp_bits[k / 4]) begin
            errors++;
            $display("FAIL rst_pre tx cycle %0d: got %b, required %b", k, tx[0], exp_bits[k / 4]);
         end
         if (k == 0) vld[0] = 1'b0;
         if (k == 10) rst = 1'b1;
         @(negedge clk);
      end
      exp_bits.delete();
      checks++;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: tx=%b busy=%b ready=%b, required 1 0 0", tx[0], busy[0], rdy[0]);
      end
      rst = 1'b0;
      @(negedge clk);
      check_idle(0, "rst_release");
      start_send(0, 8'h81, "rst_resend");
      push_frame(8'h81, 0, 0, 1);
      check_frame(0, 40, 0, -1, 8'h00, "rst_resend_0x81");
      check_idle(0, "rst_resend_end");
   endtask

   task automatic test_enable;
      en     = 1'b0;
      din    = 8'h5A;
      vld[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (rdy[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_off cycle %0d: ready=%b tx=%b busy=%b, required 0 1 0", k, rdy[0], tx[0], busy[0]);
         end
      end
      en = 1'b1;
      start_send(0, 8'h5A, "en_on");
      push_frame(8'h5A, 0, 0, 1);
      check_frame(0, 40, -1, 5, 8'h5A, "en_drop");
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (rdy[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_park cycle %0d: ready=%b tx=%b busy=%b, required 0 1 0", k, rdy[0], tx[0], busy[0]);
         end
         @(negedge clk);
      end
      en = 1'b1;
      #1;
      checks++;
      if (rdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL en_rearm ready: got %b, required 1", rdy[0]);
      end
      @(negedge clk);
      push_frame(8'h5A, 0, 0, 1);
      check_frame(0, 40, 0, -1, 8'h00, "en_rearm_frame");
      check_idle(0, "en_end");
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      din = 8'h00;
      for (int i = 0; i < 4; i++) vld[i] = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_8n1;
      test_back_to_back;
      test_parity;
      test_two_stop;
      test_mid_reset;
      test_enable;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
